// File: rtl/sys_defs.sv
// sys_defs: shared widths and the multiplier-to-CDB result entry.
package sys_defs;
    localparam int XLEN = 32;
    localparam int PRF_LEN = 6;
    localparam int ROB_LEN = 5;
    localparam int MUL_BUF_DEPTH = 8;
    localparam int MUL_STAGE = 8;

    typedef struct packed {
        logic [XLEN-1:0]    value;
        logic [PRF_LEN-1:0] prf_idx;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    PC;
    } MUL_CDB_ENTRY;
endpackage

// File: rtl/mul_result_fifo.sv
// mul_result_fifo: circular FIFO of CDB entries; caller guarantees push/pop are legal.
module mul_result_fifo
    import sys_defs::*;
#(
    parameter int DEPTH = MUL_BUF_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  MUL_CDB_ENTRY                 wr_entry,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output MUL_CDB_ENTRY                 head_entry
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    MUL_CDB_ENTRY  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    assign head_entry = mem[head];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; stale slots are never visible because count gates reads.
    always_ff @(posedge clock) begin
        if (push) mem[tail] <= wr_entry;
    end
endmodule

// File: rtl/mul_cdb_buffer.sv
// mul_cdb_buffer: buffers non-stallable multiplier results for the CDB, issues
// credits to the MUL RS, and drops results belonging to squashed ops.
module mul_cdb_buffer
    import sys_defs::*;
#(
    parameter int DEPTH   = MUL_BUF_DEPTH,
    parameter int MUL_LAT = MUL_STAGE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash,
    input  logic               mul_enable,
    output logic               mul_ready,
    input  logic               mul_valid,
    input  logic [XLEN-1:0]    mul_value,
    input  logic [PRF_LEN-1:0] mul_prf_idx,
    input  logic [ROB_LEN-1:0] mul_rob_idx,
    input  logic [XLEN-1:0]    mul_PC,
    output logic               cdb_req,
    input  logic               cdb_grant,
    output logic [XLEN-1:0]    cdb_value,
    output logic [PRF_LEN-1:0] cdb_prf_idx,
    output logic [ROB_LEN-1:0] cdb_rob_idx,
    output logic [XLEN-1:0]    cdb_PC,
    output logic               ovf_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(MUL_LAT + 1);

    logic [CW-1:0] count;
    logic [LW-1:0] inflight;
    logic [LW-1:0] inflight_next;
    logic [LW-1:0] drop_cnt;
    logic          underflow;
    logic          accept;
    logic          pop;
    logic          push;
    logic          overflow;
    MUL_CDB_ENTRY  head_entry;

    assign underflow     = mul_valid && inflight == '0;
    assign inflight_next = inflight + LW'(mul_enable) - LW'(mul_valid && !underflow);
    assign accept        = mul_valid && drop_cnt == '0 && !squash;
    assign pop           = cdb_grant && cdb_req && !squash;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign push          = accept && (count != CW'(DEPTH) || pop);
    assign overflow      = accept && !push;

    assign mul_ready   = (32'(inflight) + 32'(count)) < 32'(DEPTH);
    assign cdb_req     = count != '0;
    assign cdb_value   = head_entry.value;
    assign cdb_prf_idx = head_entry.prf_idx;
    assign cdb_rob_idx = head_entry.rob_idx;
    assign cdb_PC      = head_entry.PC;

    mul_result_fifo #(.DEPTH(DEPTH)) fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (squash),
        .push       (push),
        .pop        (pop),
        .wr_entry   ('{value: mul_value, prf_idx: mul_prf_idx, rob_idx: mul_rob_idx, PC: mul_PC}),
        .count      (count),
        .head_entry (head_entry)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight <= '0;
            drop_cnt <= '0;
            ovf_err  <= 1'b0;
        end else begin
            inflight <= inflight_next;
            ovf_err  <= ovf_err || underflow || overflow;
            if (squash) drop_cnt <= inflight_next;
            else if (mul_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        end
    end
endmodule
